// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  riscv_pkg
//  Shared types for the L0 cache write path: the AMO write interface, the
//  queued load-fill entry and address-slicing helpers.
//  Revision: 1.0
// ============================================================================
package riscv_pkg;

  localparam int RV_XLEN    = 32;
  localparam int RV_INDEX_W = 7;
  localparam int RV_TAG_W   = 7;

  typedef struct packed {
    logic               write_enable;
    logic [RV_XLEN-1:0] addr;
    logic [RV_XLEN-1:0] data;
  } amo_interface_t;

  typedef struct packed {
    logic                  valid;
    logic [RV_INDEX_W-1:0] index;
    logic [RV_TAG_W-1:0]   tag;
    logic [RV_XLEN-1:0]    data;
  } cache_fill_entry_t;

  // Word-aligned line index: bits [2 +: RV_INDEX_W]
  function automatic logic [RV_INDEX_W-1:0] addr_index(input logic [RV_XLEN-1:0] a);
    return a[2 +: RV_INDEX_W];
  endfunction

  // Tag sits directly above the index bits
  function automatic logic [RV_TAG_W-1:0] addr_tag(input logic [RV_XLEN-1:0] a);
    return a[(2+RV_INDEX_W) +: RV_TAG_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_fill_fifo.sv
`default_nettype none
// ============================================================================
//  cache_fill_fifo
//  Circular buffer of pending load fills. Every entry compares its index
//  against the current non-fill write and drops its valid bit on a match so
//  a stale fill never overwrites newer data.
//  Revision: 1.0
// ============================================================================
module cache_fill_fifo
  import riscv_pkg::*;
#(
  parameter int FillDepth = 4,
  localparam int CntW = $clog2(FillDepth) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  cache_fill_entry_t     i_push_entry,
  input  logic                  i_pop,
  input  logic                  i_squash,
  input  logic [RV_INDEX_W-1:0] i_squash_index,
  output cache_fill_entry_t     o_head,
  output logic [CntW-1:0]       o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int PtrW = $clog2(FillDepth);

  cache_fill_entry_t mem_q [FillDepth];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth)
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (i_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (i_push && !i_pop)      count_d = count_q + CntW'(1);
    else if (!i_push && i_pop) count_d = count_q - CntW'(1);
  end

  // Storage: squash matching entries first, then a push overrides its own slot
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FillDepth; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < FillDepth; i++) begin
        if (i_squash && (mem_q[i].index == i_squash_index)) mem_q[i].valid <= 1'b0;
      end
      if (i_push) mem_q[wr_ptr_q] <= i_push_entry;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;
  assign o_full  = (count_q == CntW'(FillDepth));
  assign o_empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/cache_write_arbiter_queued.sv
`default_nettype none
// ============================================================================
//  cache_write_arbiter_queued
//  L0 cache write-port controller: AMO > FP store > store > queued load fill.
//  Fills wait in a small queue, are squashed by newer writes to the same
//  index, and a registered stall is raised when the queue is full or the
//  head fill has been starved.
//  Revision: 1.0
// ============================================================================
module cache_write_arbiter_queued
  import riscv_pkg::*;
#(
  parameter int              XLEN            = RV_XLEN,
  parameter int              CacheIndexWidth = RV_INDEX_W,
  parameter int              CacheTagWidth   = RV_TAG_W,
  parameter logic [XLEN-1:0] MMIO_ADDR       = 32'h4000_0000,
  parameter int              FillDepth       = 4,
  parameter int              MaxFillWait     = 8,
  localparam int             CntW            = $clog2(FillDepth) + 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_stall_for_trap_check,
  input  logic                       i_flush,
  input  logic [XLEN-1:0]            i_store_addr,
  input  logic [XLEN-1:0]            i_store_data,
  input  logic [XLEN/8-1:0]          i_store_be,
  input  logic                       i_fill_valid,
  input  logic [XLEN-1:0]            i_fill_addr,
  input  logic [XLEN-1:0]            i_fill_data,
  input  amo_interface_t             i_amo,
  input  logic                       i_fp_we,
  input  logic [XLEN-1:0]            i_fp_addr,
  input  logic [XLEN-1:0]            i_fp_data,
  input  logic [XLEN/8-1:0]          i_fp_be,
  input  logic [CacheTagWidth-1:0]   i_cache_read_tag,
  input  logic [XLEN/8-1:0]          i_cache_read_valid,
  output logic                       o_cache_we,
  output logic [XLEN/8-1:0]          o_cache_be,
  output logic [CacheIndexWidth-1:0] o_cache_index,
  output logic [XLEN-1:0]            o_cache_data,
  output logic [CacheTagWidth-1:0]   o_cache_tag,
  output logic [XLEN/8-1:0]          o_cache_valid,
  output logic                       o_stall_request,
  output logic [CntW-1:0]            o_fill_count
);

  localparam int SW = $clog2(MaxFillWait + 1);

  logic              w_amo_act, w_fp_act, w_st_act, w_other_act;
  logic              w_head_live, w_fill_we, w_pop, w_push;
  logic              w_full, w_empty, w_starved;
  cache_fill_entry_t w_head, w_push_entry;
  logic [SW-1:0]     starve_q, starve_d;
  logic              stall_q, stall_d;

  assign w_amo_act   = i_amo.write_enable && (i_amo.addr < MMIO_ADDR);
  assign w_fp_act    = i_fp_we && (|i_fp_be) && (i_fp_addr < MMIO_ADDR);
  assign w_st_act    = (|i_store_be) && (i_store_addr < MMIO_ADDR) && !i_stall_for_trap_check;
  assign w_other_act = w_amo_act || w_fp_act || w_st_act;

  // Head writes only on an otherwise idle port; squashed heads drain without writing
  assign w_head_live = !w_empty && w_head.valid;
  assign w_fill_we   = w_head_live && !w_other_act;
  assign w_pop       = !w_empty && (!w_head.valid || w_fill_we);
  // A full queue still accepts a fill in a cycle where the head leaves
  assign w_push      = i_fill_valid && !i_flush && !i_stall_for_trap_check &&
                       (i_fill_addr < MMIO_ADDR) && (!w_full || w_pop);

  // Build the queued entry from the MA-stage load result
  always_comb begin
    w_push_entry       = '0;
    w_push_entry.valid = 1'b1;
    w_push_entry.index = addr_index(i_fill_addr);
    w_push_entry.tag   = addr_tag(i_fill_addr);
    w_push_entry.data  = i_fill_data;
  end

  // Squash uses the winning non-fill write's index, driven from o_cache_index
  cache_fill_fifo #(
    .FillDepth(FillDepth)
  ) u_fill_fifo (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_push         (w_push),
    .i_push_entry   (w_push_entry),
    .i_pop          (w_pop),
    .i_squash       (w_other_act),
    .i_squash_index (o_cache_index),
    .o_head         (w_head),
    .o_count        (o_fill_count),
    .o_full         (w_full),
    .o_empty        (w_empty)
  );

  // Priority write-port mux: AMO > FP > store > fill head
  always_comb begin
    o_cache_we    = 1'b0;
    o_cache_be    = '0;
    o_cache_index = '0;
    o_cache_data  = '0;
    o_cache_tag   = '0;
    o_cache_valid = '0;
    if (w_amo_act) begin
      o_cache_we    = 1'b1;
      o_cache_be    = '1;
      o_cache_index = addr_index(i_amo.addr);
      o_cache_data  = i_amo.data;
      o_cache_tag   = addr_tag(i_amo.addr);
      o_cache_valid = '1;
    end else if (w_fp_act) begin
      o_cache_we    = 1'b1;
      o_cache_be    = i_fp_be;
      o_cache_index = addr_index(i_fp_addr);
      o_cache_data  = i_fp_data;
      o_cache_tag   = addr_tag(i_fp_addr);
      o_cache_valid = '1;
    end else if (w_st_act) begin
      o_cache_we    = 1'b1;
      o_cache_be    = i_store_be;
      o_cache_index = addr_index(i_store_addr);
      o_cache_data  = i_store_data;
      o_cache_tag   = addr_tag(i_store_addr);
      // Same tag: merge with the line's existing valid bytes; else start fresh
      o_cache_valid = (addr_tag(i_store_addr) == i_cache_read_tag) ?
                      (i_store_be | i_cache_read_valid) : i_store_be;
    end else if (w_fill_we) begin
      o_cache_we    = 1'b1;
      o_cache_be    = '1;
      o_cache_index = w_head.index;
      o_cache_data  = w_head.data;
      o_cache_tag   = w_head.tag;
      o_cache_valid = '1;
    end
  end

  assign w_starved = (starve_q >= SW'(MaxFillWait));

  // Starvation counter saturates at the limit and clears whenever the head leaves
  always_comb begin
    starve_d = starve_q;
    if (w_pop) starve_d = '0;
    else if (w_head_live && w_other_act && !w_starved) starve_d = starve_q + SW'(1);
    stall_d = w_full || w_starved;
  end

  // Starve counter and registered stall request
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign o_stall_request = stall_q;

endmodule
`default_nettype wire
